// File: rtl/clk_divider_bank.sv
// -----------------------------------------------------------------------------
// clk_divider_bank
//
// Purpose:
//   NUM_CH independent programmable dividers / tick generators, all running on
//   one clock. Each channel counts 0..D-1 and marks the end of every period
//   with a one-cycle tick. Its clk_out either toggles on each period end
//   (mode 0: 50% duty, period 2*D) or strobes high for one cycle (mode 1:
//   period D). A new divide value written to a running channel is held until
//   the current period ends, so the outputs never see a short period.
//
// Ports:
//   clk       in   1       system clock, rising edge
//   reset_n   in   1       asynchronous active-low reset
//   en        in   NUM_CH  per-channel run enable (level)
//   mode      in   NUM_CH  0 = toggle output, 1 = strobe output
//   wr_en     in   1       divide-value write strobe (one cycle per write)
//   wr_ch     in   CH_W    target channel (values >= NUM_CH are ignored)
//   wr_data   in   WIDTH   new divide value D (0 = idle channel)
//   clk_out   out  NUM_CH  divided output per channel (registered)
//   tick      out  NUM_CH  one-cycle pulse at each period end (registered)
//   pending   out  NUM_CH  a written value is waiting for the period end
// -----------------------------------------------------------------------------
module clk_divider_bank #(
  parameter int          NUM_CH    = 4,
  parameter int          WIDTH     = 32,
  parameter int unsigned RESET_DIV = 0,
  localparam int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] mode,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] DIV_INIT = WIDTH'(RESET_DIV);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [WIDTH-1:0] div_act_reg;
      logic [WIDTH-1:0] div_pend_reg;
      logic [WIDTH-1:0] cnt_reg;
      logic             pend_v_reg;
      logic             mode_act_reg;
      logic             clk_out_reg;
      logic             tick_reg;

      logic             wr_hit;
      logic             active;
      logic             term;
      logic [WIDTH-1:0] div_next;

      // Out-of-range channel numbers can never equal gi, so they fall through.
      assign wr_hit = wr_en && (wr_ch == CH_W'(gi));
      assign active = en[gi] && (div_act_reg != '0);
      // div_act_reg is non-zero whenever active, so the subtraction cannot wrap.
      assign term   = active && (cnt_reg >= (div_act_reg - ONE));

      // Divide value that takes over at a period boundary (or while stopped):
      // a write landing on this very cycle beats any older pending value.
      assign div_next = wr_hit     ? wr_data      :
                        pend_v_reg ? div_pend_reg : div_act_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          div_act_reg  <= DIV_INIT;
          div_pend_reg <= '0;
          cnt_reg      <= '0;
          pend_v_reg   <= 1'b0;
          mode_act_reg <= 1'b0;
          clk_out_reg  <= 1'b0;
          tick_reg     <= 1'b0;
        end else begin
          tick_reg <= term;
          if (!active) begin
            // Disabled or idle: nothing is mid-period, so any new value
            // applies at once and the output parks low.
            div_act_reg  <= div_next;
            pend_v_reg   <= 1'b0;
            cnt_reg      <= '0;
            clk_out_reg  <= 1'b0;
            mode_act_reg <= mode[gi];
          end else if (term) begin
            div_act_reg  <= div_next;
            pend_v_reg   <= 1'b0;
            cnt_reg      <= '0;
            mode_act_reg <= mode[gi];
            if (div_next == '0) begin
              clk_out_reg <= 1'b0;          // channel goes idle after this period
            end else if (mode[gi]) begin
              clk_out_reg <= 1'b1;
            end else begin
              clk_out_reg <= ~clk_out_reg;
            end
          end else begin
            cnt_reg <= cnt_reg + ONE;
            if (wr_hit) begin
              div_pend_reg <= wr_data;
              pend_v_reg   <= 1'b1;
            end
            // A mode change only applies from the next period end; until
            // then the output follows the mode latched at the last boundary.
            if (mode_act_reg) begin
              clk_out_reg <= 1'b0;
            end
          end
        end
      end

      assign clk_out[gi] = clk_out_reg;
      assign tick[gi]    = tick_reg;
      assign pending[gi] = pend_v_reg;
    end
  endgenerate

endmodule

// File: tb/tb_clk_divider_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_divider_bank
//
// Self-checking bench for clk_divider_bank (5 channels, 8-bit values so the
// largest legal divide value 255 can be exercised). A behavioural model of
// each channel (period counter, active/pending divide values) is advanced on
// every rising edge; directed scenarios also check constants derived directly
// from the expected periods.
// -----------------------------------------------------------------------------
module tb_clk_divider_bank;

  localparam int NUM_CH = 5;
  localparam int WIDTH  = 8;
  localparam int CH_W   = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] mode;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [WIDTH-1:0]  wr_data;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pending;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state per channel
  int m_div  [NUM_CH];
  int m_pend [NUM_CH];
  int m_pos  [NUM_CH];   // position inside the current period
  bit m_pv   [NUM_CH];
  bit m_mode [NUM_CH];
  bit m_clk  [NUM_CH];
  bit m_tick [NUM_CH];

  always #5 clk = ~clk;

  clk_divider_bank #(
    .NUM_CH   (NUM_CH),
    .WIDTH    (WIDTH),
    .RESET_DIV(0)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (en),
    .mode   (mode),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_data(wr_data),
    .clk_out(clk_out),
    .tick   (tick),
    .pending(pending)
  );

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_div[c] = 0; m_pend[c] = 0; m_pos[c] = 0;
      m_pv[c] = 0; m_mode[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
    end
  endfunction

  // One rising edge of the behavioural model, using the inputs now applied.
  function automatic void model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      bit hit, running, period_end;
      int d;
      hit        = wr_en && (int'(wr_ch) == c);
      running    = en[c] && (m_div[c] != 0);
      period_end = running && (m_pos[c] == m_div[c] - 1);
      m_tick[c]  = period_end;
      if (!running) begin
        if (hit) m_div[c] = int'(wr_data);
        else if (m_pv[c]) m_div[c] = m_pend[c];
        m_pv[c] = 0; m_pos[c] = 0; m_clk[c] = 0; m_mode[c] = mode[c];
      end else if (period_end) begin
        d = hit ? int'(wr_data) : (m_pv[c] ? m_pend[c] : m_div[c]);
        m_div[c] = d; m_pv[c] = 0; m_pos[c] = 0;
        m_clk[c] = (d == 0) ? 1'b0 : (mode[c] ? 1'b1 : !m_clk[c]);
        m_mode[c] = mode[c];
      end else begin
        m_pos[c]++;
        if (hit) begin m_pend[c] = int'(wr_data); m_pv[c] = 1; end
        if (m_mode[c]) m_clk[c] = 0;
      end
    end
  endfunction

  function automatic logic [NUM_CH-1:0] exp_clk();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_clk[c];
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_tick();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_tick[c];
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_pend();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_pv[c];
    return v;
  endfunction

  // Advance one clock; outputs are then sampled at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = '0; mode = '0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({clk_out, tick, pending} !== '0) begin
      miscompares++;
      $display("FAIL reset_hold: got clk_out=%b tick=%b pending=%b, want all 0", clk_out, tick, pending);
    end
    reset_n = 1'b1; en = '1; mode = NUM_CH'($urandom);
    for (int k = 1; k <= 100; k++) begin
      cycle();
      vectors++;
      if ({clk_out, tick, pending} !== '0) begin
        miscompares++;
        $display("FAIL reset_idle k=%0d: got clk_out=%b tick=%b pending=%b, want all 0", k, clk_out, tick, pending);
      end
    end
  endtask

  task automatic test_toggle();
    en = '0; mode = '0;
    wr_en = 1'b1; wr_ch = 3'd0; wr_data = 8'd3;
    cycle();
    wr_en = 1'b0;
    en[0] = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      logic et, ec;
      cycle();
      et = (k % 3 == 0);
      ec = ((k / 3) % 2 == 1);
      vectors++;
      if (tick[0] !== et || clk_out[0] !== ec || pending[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL toggle k=%0d: got tick=%b clk_out=%b pending=%b, want %b %b 0", k, tick[0], clk_out[0], pending[0], et, ec);
      end
    end
  endtask

  task automatic test_strobe();
    en[1] = 1'b0; mode[1] = 1'b1;
    wr_en = 1'b1; wr_ch = 3'd1; wr_data = 8'd1;
    cycle();
    wr_en = 1'b0;
    en[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      vectors++;
      if (clk_out[1] !== 1'b1 || tick[1] !== 1'b1) begin
        miscompares++;
        $display("FAIL strobe_d1 k=%0d: got clk_out=%b tick=%b, want 1 1", k, clk_out[1], tick[1]);
      end
    end
    wr_en = 1'b1; wr_ch = 3'd1; wr_data = 8'd5;
    for (int j = 0; j <= 20; j++) begin
      logic e;
      cycle();
      wr_en = 1'b0;
      e = (j % 5 == 0);
      vectors++;
      if (clk_out[1] !== e || tick[1] !== e || pending[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL strobe_d5 j=%0d: got clk_out=%b tick=%b pending=%b, want %b %b 0", j, clk_out[1], tick[1], pending[1], e, e);
      end
    end
  endtask

  task automatic test_deferred();
    int pend_cnt, tick_cnt;
    bit found;
    en[2] = 1'b0; mode[2] = 1'b0;
    wr_en = 1'b1; wr_ch = 3'd2; wr_data = 8'd10;
    cycle();
    wr_en = 1'b0;
    en[2] = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (m_pos[2] == 2) found = 1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL deferred_setup: counter position 2 not reached in 20 cycles, got %0d", m_pos[2]);
    end
    wr_en = 1'b1; wr_ch = 3'd2; wr_data = 8'd2;
    pend_cnt = 0; tick_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      wr_en = 1'b0;
      if (pending[2]) pend_cnt++;
      if (tick[2]) tick_cnt++;
      vectors++;
      if ({clk_out, tick, pending} !== {exp_clk(), exp_tick(), exp_pend()}) begin
        miscompares++;
        $display("FAIL deferred_model i=%0d: got clk_out=%b tick=%b pending=%b, want %b %b %b", i, clk_out, tick, pending, exp_clk(), exp_tick(), exp_pend());
      end
    end
    vectors++;
    if (pend_cnt != 7 || tick_cnt != 12) begin
      miscompares++;
      $display("FAIL deferred_counts: got pending cycles=%0d ticks=%0d, want 7 and 12", pend_cnt, tick_cnt);
    end
  endtask

  task automatic test_collisions();
    en[3] = 1'b0; mode[3] = 1'b1;
    wr_en = 1'b1; wr_ch = 3'd3; wr_data = 8'd4;
    cycle();
    wr_en = 1'b0;
    en[3] = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      logic et, ep;
      wr_en = (i == 1 || i == 2 || i == 16);
      wr_ch = 3'd3;
      wr_data = (i == 1) ? 8'd6 : (i == 2) ? 8'd3 : 8'd2;
      cycle();
      wr_en = 1'b0;
      et = (i == 4 || i == 7 || i == 10 || i == 13 || i == 16 || i == 18 || i == 20 || i == 22);
      ep = (i >= 1 && i <= 3);
      vectors++;
      if (tick[3] !== et || clk_out[3] !== et || pending[3] !== ep) begin
        miscompares++;
        $display("FAIL collision i=%0d: got tick=%b clk_out=%b pending=%b, want %b %b %b", i, tick[3], clk_out[3], pending[3], et, et, ep);
      end
    end
    for (int i = 0; i < 12; i++) begin
      wr_en = (i < 6); wr_ch = CH_W'(5 + (i % 3)); wr_data = WIDTH'($urandom_range(0, 9));
      cycle();
      wr_en = 1'b0;
      vectors++;
      if ({clk_out, tick, pending} !== {exp_clk(), exp_tick(), exp_pend()}) begin
        miscompares++;
        $display("FAIL bad_channel i=%0d: got clk_out=%b tick=%b pending=%b, want %b %b %b", i, clk_out, tick, pending, exp_clk(), exp_tick(), exp_pend());
      end
    end
  endtask

  task automatic test_boundary();
    en[4] = 1'b0; mode[4] = 1'b0;
    wr_en = 1'b1; wr_ch = 3'd4; wr_data = 8'd255;
    cycle();
    wr_en = 1'b0;
    en[4] = 1'b1;
    for (int k = 1; k <= 520; k++) begin
      logic et, ec, ep;
      wr_en = (k == 257); wr_ch = 3'd4; wr_data = 8'd0;
      cycle();
      wr_en = 1'b0;
      et = (k == 255 || k == 510);
      ec = (k >= 255 && k < 510);
      ep = (k >= 257 && k < 510);
      vectors++;
      if (tick[4] !== et || clk_out[4] !== ec || pending[4] !== ep) begin
        miscompares++;
        $display("FAIL boundary k=%0d: got tick=%b clk_out=%b pending=%b, want %b %b %b", k, tick[4], clk_out[4], pending[4], et, ec, ep);
      end
    end
  endtask

  task automatic test_disruption();
    bit seen;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      cycle();
      if (clk_out != '0) seen = 1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL disrupt_setup: got clk_out=%b for 10 cycles, want some channel high", clk_out);
    end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if ({clk_out, tick, pending} !== '0) begin
      miscompares++;
      $display("FAIL reset_async: got clk_out=%b tick=%b pending=%b, want all 0", clk_out, tick, pending);
    end
    @(negedge clk);
    reset_n = 1'b1; en = '1;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      vectors++;
      if ({clk_out, tick, pending} !== '0) begin
        miscompares++;
        $display("FAIL reset_div k=%0d: got clk_out=%b tick=%b pending=%b, want all 0", k, clk_out, tick, pending);
      end
    end
    en = '0; mode = '0;
    wr_en = 1'b1; wr_ch = 3'd0; wr_data = 8'd4;
    cycle();
    en[0] = 1'b1; wr_en = 1'b0;
    cycle();
    wr_en = 1'b1; wr_data = 8'd2;
    cycle();
    wr_en = 1'b0;
    vectors++;
    if (pending[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL en_drop_pend: got pending=%b, want 1", pending[0]);
    end
    en[0] = 1'b0;
    cycle();
    vectors++;
    if (pending[0] !== 1'b0 || clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL en_drop: got pending=%b clk_out=%b tick=%b, want 0 0 0", pending[0], clk_out[0], tick[0]);
    end
    cycle();
    en[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      vectors++;
      if (tick[0] !== (k % 2 == 0) || pending[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL reenable k=%0d: got tick=%b pending=%b, want %b 0", k, tick[0], pending[0], (k % 2 == 0));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 99) < 5) en[c] = ~en[c];
        if ($urandom_range(0, 99) < 3) mode[c] = ~mode[c];
      end
      wr_en   = ($urandom_range(0, 99) < 25);
      wr_ch   = CH_W'($urandom_range(0, 7));
      wr_data = ($urandom_range(0, 49) == 0) ? WIDTH'($urandom_range(20, 40)) : WIDTH'($urandom_range(0, 7));
      cycle();
      vectors++;
      if ({clk_out, tick, pending} !== {exp_clk(), exp_tick(), exp_pend()}) begin
        miscompares++;
        $display("FAIL random i=%0d: got clk_out=%b tick=%b pending=%b, want %b %b %b", i, clk_out, tick, pending, exp_clk(), exp_tick(), exp_pend());
      end
    end
    wr_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_strobe();
    test_deferred();
    test_collisions();
    test_boundary();
    test_disruption();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
